// File: rtl/mem_target.sv
// mem_target: word-addressed memory target with req/ack handshake, optional ack gap
// and a fixed-latency read response pipeline.
module mem_target #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 2,
    parameter int ACK_GAP    = 0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req,
    input  logic [AWIDTH-1:0] addr,
    input  logic              cmd,
    input  logic [DWIDTH-1:0] wdata,
    output logic              ack,
    output logic [DWIDTH-1:0] rdata,
    output logic              resp
);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0][DWIDTH-1:0]      mem;
    logic [RD_LATENCY-1:0][DWIDTH-1:0] pipe_data;
    logic [RD_LATENCY-1:0]             pipe_vld;
    logic [2:0]                        gap;
    logic [IW-1:0]                     idx;
    logic                              rd_acc;
    logic                              unused_addr;

    assign idx         = addr[IW+1:2];
    assign unused_addr = ^addr;
    assign ack         = req && gap == 3'd0 && aresetn;
    assign rd_acc      = ack && !cmd;
    assign resp        = pipe_vld[RD_LATENCY-1];
    assign rdata       = resp ? pipe_data[RD_LATENCY-1] : '0;

    // read samples mem before this edge's write lands (non-blocking update)
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem       <= '0;
            pipe_data <= '0;
            pipe_vld  <= '0;
            gap       <= '0;
        end else begin
            gap          <= ack ? 3'(ACK_GAP) : gap - 3'(gap != 3'd0);
            pipe_vld[0]  <= rd_acc;
            pipe_data[0] <= rd_acc ? mem[idx] : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
            if (ack && cmd)
                mem[idx] <= wdata;
        end
    end
endmodule

// File: tb/tb_mem_target.sv
// tb_mem_target: checks three mem_target configurations against a cycle-level
// reference model (memory array, gap counter, response schedule).
module tb_mem_target;
    localparam int N = 3;

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req [N];
    logic        cmd [N];
    logic        ack [N];
    logic        resp [N];
    logic [31:0] addr [N];
    logic [31:0] wdata [N];
    logic [31:0] rdata [N];

    int          lat [N] = '{2, 3, 1};
    int          gap_p [N] = '{0, 0, 2};
    logic [31:0] mm [N][16];
    int          gcnt [N];
    logic        sv [N][16];
    logic [31:0] sd [N][16];
    logic        acc_last [N];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        log0 = 0, log1 = 0, log2 = 0;
    logic [31:0] got0 [$];
    int          c1 [$];
    logic [31:0] d1 [$];
    logic        ack2_hist [$];

    always #5 aclk = ~aclk;

    mem_target dut0 (
        .aclk(aclk), .aresetn(aresetn), .req(req[0]), .addr(addr[0]), .cmd(cmd[0]),
        .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .resp(resp[0])
    );
    mem_target #(.RD_LATENCY(3)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .req(req[1]), .addr(addr[1]), .cmd(cmd[1]),
        .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .resp(resp[1])
    );
    mem_target #(.RD_LATENCY(1), .ACK_GAP(2)) dut2 (
        .aclk(aclk), .aresetn(aresetn), .req(req[2]), .addr(addr[2]), .cmd(cmd[2]),
        .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .resp(resp[2])
    );

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            gcnt[k] = 0;
            acc_last[k] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                mm[k][i] = '0;
                sv[k][i] = 1'b0;
                sd[k][i] = '0;
            end
        end
    endtask

    task automatic drive(int k, logic r, logic c, logic [31:0] a, logic [31:0] d);
        req[k] = r;
        cmd[k] = c;
        addr[k] = a;
        wdata[k] = d;
    endtask

    // compare at negedge, advance the model at posedge, return 1 time unit later
    task automatic tick();
        @(negedge aclk);
        for (int k = 0; k < N; k++) begin
            int s;
            s = cyc % 16;
            chk($sformatf("ack%0d", k), 32'(ack[k]), 32'(aresetn && req[k] && gcnt[k] == 0));
            chk($sformatf("resp%0d", k), 32'(resp[k]), 32'(sv[k][s]));
            chk($sformatf("rdata%0d", k), rdata[k], sv[k][s] ? sd[k][s] : 32'h0);
            sv[k][s] = 1'b0;
        end
        if (log0 && resp[0]) got0.push_back(rdata[0]);
        if (log1 && resp[1]) begin
            c1.push_back(cyc);
            d1.push_back(rdata[1]);
        end
        if (log2) ack2_hist.push_back(ack[2]);
        @(posedge aclk);
        for (int k = 0; k < N; k++) begin
            logic acc;
            acc = aresetn && req[k] && gcnt[k] == 0;
            acc_last[k] = acc;
            if (aresetn) gcnt[k] = acc ? gap_p[k] : (gcnt[k] > 0 ? gcnt[k] - 1 : 0);
            if (acc && cmd[k]) mm[k][addr[k][5:2]] = wdata[k];
            if (acc && !cmd[k]) begin
                sv[k][(cyc + lat[k]) % 16] = 1'b1;
                sd[k][(cyc + lat[k]) % 16] = mm[k][addr[k][5:2]];
            end
        end
        cyc++;
        #1;
    endtask

    task automatic pulse_reset();
        aresetn = 1'b0;
        model_clear();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [13];
        logic [31:0] exp_rd [$];
        int          first;
        int          j;
        tbl[0]  = '{1'b0, 32'h0000_0004, 32'h0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0044, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0};
        tbl[3]  = '{1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b1, 32'h0000_0014, 32'h0000_000A, 32'h0};
        tbl[5]  = '{1'b0, 32'h0000_0014, 32'h0, 32'h0000_000A};
        tbl[6]  = '{1'b1, 32'h0000_0014, 32'h0000_000B, 32'h0};
        tbl[7]  = '{1'b0, 32'h0000_0014, 32'h0, 32'h0000_000B};
        tbl[8]  = '{1'b1, 32'h0000_0048, 32'h1111_1111, 32'h0};
        tbl[9]  = '{1'b0, 32'h0000_0008, 32'h0, 32'h1111_1111};
        tbl[10] = '{1'b0, 32'h0000_003C, 32'h0, 32'h0};
        tbl[11] = '{1'b1, 32'h0000_003C, 32'hFFFF_FFFF, 32'h0};
        tbl[12] = '{1'b0, 32'h8000_00FC, 32'h0, 32'hFFFF_FFFF};

        model_clear();
        for (int k = 0; k < N; k++) drive(k, 1'b1, 1'b0, 32'h4, 32'h0);
        tick();
        tick();
        aresetn = 1'b1;
        for (int k = 0; k < N; k++) drive(k, 1'b0, 1'b0, 32'h0, 32'h0);

        // back-to-back table on the default configuration
        log0 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(0, 1'b1, tbl[i].cmd, tbl[i].addr, tbl[i].wdata);
            if (!tbl[i].cmd) exp_rd.push_back(tbl[i].exp);
            tick();
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();
        log0 = 1'b0;
        chk("tbl_count", 32'(got0.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < got0.size(); i++)
            chk($sformatf("tbl_rd%0d", i), got0[i], exp_rd[i]);

        // latency 3: four back-to-back reads of pre-written words
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 1'b1, 32'(i * 4), 32'h10 + 32'(i));
            tick();
        end
        log1 = 1'b1;
        first = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 1'b0, 32'(i * 4), 32'h0);
            tick();
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) tick();
        log1 = 1'b0;
        chk("lat3_count", 32'(c1.size()), 32'd4);
        for (int i = 0; i < 4 && i < c1.size(); i++) begin
            chk($sformatf("lat3_cyc%0d", i), 32'(c1[i]), 32'(first + 2 + i));
            chk($sformatf("lat3_dat%0d", i), d1[i], 32'h10 + 32'(i));
        end

        // gap 2: req held high, data advanced after each acceptance
        log2 = 1'b1;
        j = 0;
        for (int i = 0; i < 9; i++) begin
            drive(2, 1'b1, 1'b1, 32'(j * 4), 32'hA0 + 32'(j));
            tick();
            if (acc_last[2]) j++;
        end
        log2 = 1'b0;
        chk("gap_accepts", 32'(j), 32'd3);
        for (int i = 0; i < 9 && i < ack2_hist.size(); i++)
            chk($sformatf("gap_ack%0d", i), 32'(ack2_hist[i]), 32'(i % 3 == 0));
        j = 0;
        for (int i = 0; i < 9; i++) begin
            drive(2, 1'b1, 1'b0, 32'(j * 4), 32'h0);
            tick();
            if (acc_last[2]) j++;
        end
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();

        // reset while a read is in flight
        drive(0, 1'b1, 1'b1, 32'h8, 32'h5555_AAAA);
        tick();
        drive(0, 1'b1, 1'b0, 32'h8, 32'h0);
        tick();
        pulse_reset();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();
        got0.delete();
        log0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 1'b0, 32'(i * 4), 32'h0);
            tick();
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();
        log0 = 1'b0;
        chk("rst_count", 32'(got0.size()), 32'd16);
        for (int i = 0; i < got0.size(); i++)
            chk($sformatf("rst_mem%0d", i), got0[i], 32'h0);

        // randomized traffic on all three configurations
        for (int c = 0; c < 900; c++) begin
            for (int k = 0; k < N; k++)
                if (!req[k] || acc_last[k])
                    drive(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom(), $urandom());
            if (c == 450) pulse_reset();
            else tick();
        end
        for (int k = 0; k < N; k++) drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_target.md
MEM_TARGET -- requirements
Module: mem_target

Interface
REQ-001 Parameter AWIDTH, default 32, address width of the request port.
REQ-002 Parameter DWIDTH, default 32, data width of wdata and rdata.
REQ-003 Parameter DEPTH, default 16, number of DWIDTH-bit words stored; power of two, minimum 2.
REQ-004 Parameter RD_LATENCY, default 2, cycles from read acceptance to resp; legal range 1..8.
REQ-005 Parameter ACK_GAP, default 0, idle cycles forced after each acceptance; legal range 0..7.
REQ-006 aclk  input  1  sole clock; all state updates on its rising edge.
REQ-007 aresetn  input  1  reset, asynchronous and active-low.
REQ-008 req  input  1  master request; held high with addr/cmd/wdata stable until ack.
REQ-009 addr  input  AWIDTH  byte address; word index = addr[log2(DEPTH)+1:2], other bits ignored.
REQ-010 cmd  input  1  0 = read, 1 = write.
REQ-011 wdata  input  DWIDTH  write data, valid with req when cmd=1.
REQ-012 ack  output  1  acceptance strobe, one cycle per accepted request.
REQ-013 rdata  output  DWIDTH  read data, valid only while resp=1.
REQ-014 resp  output  1  read-response strobe, one cycle per accepted read.

Function
REQ-015 ack SHALL be combinational: ack = req AND (gap counter == 0) AND not in reset.
REQ-016 A request is accepted on a rising edge where req=1 and ack=1.
REQ-017 On an accepted write, mem[word index] SHALL take wdata at that edge; writes produce no resp.
REQ-018 On an accepted read, mem[word index] SHALL be sampled at the acceptance edge, from contents before any write on that same edge.
REQ-019 The sampled read SHALL enter a RD_LATENCY-stage valid/data shift pipeline.
REQ-020 resp=1 with rdata = sampled word SHALL occur in exactly the RD_LATENCY-th cycle after the acceptance edge (RD_LATENCY=1: the cycle immediately following acceptance).
REQ-021 rdata SHALL be 0 whenever resp=0.
REQ-022 Writes accepted after a read's acceptance SHALL NOT alter that read's returned data.
REQ-023 With ACK_GAP=0, one request SHALL be accepted per cycle with no bubbles; back-to-back reads yield back-to-back resp pulses in acceptance order.
REQ-024 On each acceptance, the gap counter SHALL load ACK_GAP, then decrement by 1 per cycle to 0; ack SHALL be held 0 while it is nonzero, regardless of req.
REQ-025 Read responses SHALL never be reordered, merged or dropped outside reset; responses in flight are unaffected by the gap counter.
REQ-026 req=0 SHALL cause no state change other than pipeline advance and gap-counter decrement.
REQ-027 Read and write to the same word on consecutive accepted cycles: the read returns the value written (write at edge k visible to a read accepted at edge k+1).

Reset
REQ-028 While aresetn=0: ack=0, resp=0, rdata=0, gap counter=0, all pipeline valid bits=0, every memory word=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight reads; no resp SHALL appear for them after release.
REQ-030 First acceptance is possible on the first rising edge after aresetn deasserts.

Verification
REQ-031 Defaults; write addr=0x8 data=0xDEADBEEF, then read addr=0x8 -> ack in each request cycle, resp=1 rdata=0xDEADBEEF exactly 2 cycles after read acceptance.
REQ-032 Defaults; read addr=0x4 after reset -> resp=1 with rdata=0x00000000; addr=0x44 aliases to word 1 -> same value as 0x4.
REQ-033 RD_LATENCY=3; four back-to-back reads of words 0..3 pre-written with 0x10..0x13 -> four consecutive resp pulses with 0x10,0x11,0x12,0x13, first 3 cycles after first acceptance.
REQ-034 ACK_GAP=2; req held high continuously -> ack pattern 1,0,0,1,0,0,...; data applied per request written/read correctly.
REQ-035 Read word 5 (value 0xA) accepted, write 0xB to word 5 next cycle -> resp returns 0xA; subsequent read returns 0xB.
REQ-036 Read accepted, aresetn pulsed low for 1 cycle before resp -> no resp after release; ack, resp, rdata 0 during reset; memory reads back 0.
